// File: rtl/fp_pkg.sv
// fp_pkg: shared types, format constants and helpers for the fp_add slice.
//   rm_e        rounding-mode encoding (101-111 fall through to RNE)
//   OP_*        op_type codes
//   D_* / S_*   binary64 / binary32 format constants
//   unp_t       unpacked operand, both formats mapped onto a 53-bit significand
package fp_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RZ  = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  localparam int unsigned D_EXP_W  = 11;
  localparam int unsigned D_FRAC_W = 52;
  localparam int unsigned S_EXP_W  = 8;
  localparam int unsigned S_FRAC_W = 23;

  localparam logic signed [13:0] D_BIAS     = 14'sd1023;
  localparam logic signed [13:0] S_BIAS     = 14'sd127;
  localparam logic signed [13:0] D_EXP_MAX  = 14'sd2046;
  localparam logic signed [13:0] S_EXP_MAX  = 14'sd254;
  localparam logic signed [13:0] D_TRAP_ADJ = 14'sd1536;
  localparam logic signed [13:0] S_TRAP_ADJ = 14'sd192;

  localparam logic [63:0] D_QNAN = 64'h7FF8000000000000;
  localparam logic [63:0] S_QNAN = 64'h000000007FC00000;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  // Single operands are left-justified into the double-width significand so
  // the whole datapath is shared; only the rounding position differs.
  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [52:0] sig;
    logic        nan;
    logic        snan;
    logic        inf;
  } unp_t;

  function automatic unp_t fp_unpack(input logic [63:0] x, input logic p);
    unp_t u;
    logic exp_ones;
    if (p) begin
      u.sign   = x[31];
      u.exp    = {3'b000, x[30:23]};
      u.sig    = {1'b0, x[22:0], 29'b0};
      exp_ones = &x[30:23];
    end else begin
      u.sign   = x[63];
      u.exp    = x[62:52];
      u.sig    = {1'b0, x[51:0]};
      exp_ones = &x[62:52];
    end
    u.sig[52] = (u.exp != '0);
    u.nan     = exp_ones & (u.sig[51:0] != '0);
    u.snan    = u.nan & ~u.sig[51];
    u.inf     = exp_ones & (u.sig[51:0] == '0);
    return u;
  endfunction

  function automatic logic [63:0] fp_pack(input logic s, input logic [10:0] ef,
                                          input logic [51:0] frac, input logic p);
    return p ? {32'b0, s, ef[7:0], frac[51:29]} : {s, ef, frac};
  endfunction

endpackage

// File: rtl/fp_round.sv
// fp_round: rounds a normalized significand (hidden bit at [55], three extra
// bits below the double LSB) to double or single precision.
//   sign, exp_in, sig_in, rm, P  -> value to round and how
//   exp_out, hidden, frac        -> rounded exponent, leading bit, fraction
//                                   (single fraction in frac[51:29])
//   inexact, overflow            -> discarded bits nonzero / exponent above max
module fp_round
  import fp_pkg::*;
(
  input  logic               sign,
  input  logic signed [13:0] exp_in,
  input  logic [55:0]        sig_in,
  input  logic [2:0]         rm,
  input  logic               P,
  output logic signed [13:0] exp_out,
  output logic               hidden,
  output logic [51:0]        frac,
  output logic               inexact,
  output logic               overflow
);

  logic        lsb;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [53:0] inc;
  logic [53:0] sum;

  always_comb begin
    if (P) begin
      lsb    = sig_in[32];
      guard  = sig_in[31];
      sticky = |sig_in[30:0];
      inc    = 54'd1 << 29;
    end else begin
      lsb    = sig_in[3];
      guard  = sig_in[2];
      sticky = |sig_in[1:0];
      inc    = 54'd1;
    end
    inexact = guard | sticky;

    case (rm)
      RM_RZ:   round_up = 1'b0;
      RM_RDN:  round_up = sign & inexact;
      RM_RUP:  round_up = ~sign & inexact;
      RM_RMM:  round_up = guard;
      default: round_up = guard & (sticky | lsb);
    endcase

    sum = {1'b0, sig_in[55:3]} + (round_up ? inc : '0);

    // Carry out of the significand means 10.000..., so renormalize.
    if (sum[53]) begin
      exp_out = exp_in + 14'sd1;
      hidden  = 1'b1;
      frac    = sum[52:1];
    end else begin
      exp_out = exp_in;
      hidden  = sum[52];
      frac    = sum[51:0];
    end
    if (P) frac[28:0] = '0;

    overflow = exp_out > (P ? S_EXP_MAX : D_EXP_MAX);
  end

endmodule

// File: rtl/fp_add.sv
// fp_add: IEEE 754 binary64/binary32 adder/subtractor, combinational result
// plus a registered sticky exception accumulator.
//   clk, reset      clock and synchronous active-low reset (sticky_flags only)
//   op1, op2        operands (single in [31:0] when P=1)
//   rm, op_type     rounding mode, 000 add / 001 subtract
//   P               0 double, 1 single
//   OvEn, UnEn      overflow / underflow trap enables
//   result          rounded sum (single in [31:0], upper half zero)
//   Flags           {NV, DZ, OF, UF, NX}
//   Denorm          result is a finite subnormal
//   sticky_flags    OR-accumulation of Flags since reset
module fp_add
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  input  logic [2:0]  rm,
  input  logic [2:0]  op_type,
  input  logic        P,
  input  logic        OvEn,
  input  logic        UnEn,
  output logic [63:0] result,
  output logic [4:0]  Flags,
  output logic        Denorm,
  output logic [4:0]  sticky_flags
);

  unp_t               u1, u2;
  logic               s2;
  logic               eff_sub;
  logic               swap;
  logic               res_sign;
  logic               zero_sign;
  logic [10:0]        e1, e2, ea, eb, ediff, ea_m1;
  logic [52:0]        siga, sigb;
  logic [5:0]         sh;
  logic [55:0]        b_ext, b_shift, b_mask;
  logic               b_sticky;
  logic [56:0]        a_al, b_al, sum;
  logic [5:0]         lz;
  logic [5:0]         nsh;
  logic [55:0]        norm;
  logic signed [13:0] exp_pre;
  logic               is_zero;

  logic signed [13:0] r_exp;
  logic               r_hidden;
  logic [51:0]        r_frac;
  logic               r_inexact;
  logic               r_ovf;

  logic               tiny;
  logic               to_inf;
  logic signed [13:0] ef;
  logic signed [13:0] adj;

  always_comb begin
    u1      = fp_unpack(op1, P);
    u2      = fp_unpack(op2, P);
    s2      = u2.sign ^ (op_type == OP_SUB);
    eff_sub = u1.sign ^ s2;

    e1 = (u1.exp == '0) ? 11'd1 : u1.exp;
    e2 = (u2.exp == '0) ? 11'd1 : u2.exp;

    // Larger magnitude goes to 'a' so a subtract never goes negative.
    swap     = {e2, u2.sig} > {e1, u1.sig};
    ea       = swap ? e2 : e1;
    eb       = swap ? e1 : e2;
    siga     = swap ? u2.sig : u1.sig;
    sigb     = swap ? u1.sig : u2.sig;
    res_sign = swap ? s2 : u1.sign;
    ediff    = ea - eb;

    sh       = (ediff > 11'd56) ? 6'd56 : ediff[5:0];
    b_ext    = {sigb, 3'b000};
    b_shift  = b_ext >> sh;
    b_mask   = ~({56{1'b1}} << sh);
    b_sticky = |(b_ext & b_mask);

    a_al = {1'b0, siga, 3'b000};
    b_al = {1'b0, b_shift[55:1], b_shift[0] | b_sticky};
    sum  = eff_sub ? (a_al - b_al) : (a_al + b_al);

    is_zero   = (sum == '0);
    zero_sign = (u1.sign == s2) ? u1.sign : (rm == RM_RDN);

    lz = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      if (sum[i]) lz = 6'(55 - i);
    end

    // Without the underflow trap, the left shift stops at exponent 1 so the
    // result lands directly in subnormal form (hidden bit 0).
    ea_m1 = ea - 11'd1;
    nsh   = lz;
    norm  = '0;
    if (sum[56]) begin
      norm    = {sum[56:2], sum[1] | sum[0]};
      exp_pre = $signed({3'b000, ea}) + 14'sd1;
    end else begin
      if (!UnEn && ({5'b0, lz} > ea_m1)) nsh = ea_m1[5:0];
      norm    = sum[55:0] << nsh;
      exp_pre = $signed({3'b000, ea}) - $signed({8'b0, nsh});
    end
  end

  fp_round u_round (
    .sign     (res_sign),
    .exp_in   (exp_pre),
    .sig_in   (norm),
    .rm       (rm),
    .P        (P),
    .exp_out  (r_exp),
    .hidden   (r_hidden),
    .frac     (r_frac),
    .inexact  (r_inexact),
    .overflow (r_ovf)
  );

  always_comb begin
    Flags  = '0;
    result = '0;
    adj    = P ? S_TRAP_ADJ : D_TRAP_ADJ;
    tiny   = ~is_zero & (~r_hidden | (r_exp < 14'sd1));
    ef     = r_exp;

    case (rm)
      RM_RZ:   to_inf = 1'b0;
      RM_RDN:  to_inf = res_sign;
      RM_RUP:  to_inf = ~res_sign;
      default: to_inf = 1'b1;
    endcase

    if (u1.nan || u2.nan) begin
      result         = P ? S_QNAN : D_QNAN;
      Flags[FLAG_NV] = u1.snan | u2.snan;
    end else if (u1.inf && u2.inf && eff_sub) begin
      result         = P ? S_QNAN : D_QNAN;
      Flags[FLAG_NV] = 1'b1;
    end else if (u1.inf) begin
      result = fp_pack(u1.sign, '1, '0, P);
    end else if (u2.inf) begin
      result = fp_pack(s2, '1, '0, P);
    end else if (is_zero) begin
      result = fp_pack(zero_sign, '0, '0, P);
    end else if (r_ovf && !OvEn) begin
      Flags[FLAG_OF] = 1'b1;
      Flags[FLAG_NX] = 1'b1;
      if (to_inf) result = fp_pack(res_sign, '1, '0, P);
      else        result = fp_pack(res_sign, P ? 11'd254 : 11'd2046, '1, P);
    end else begin
      if (r_ovf)             ef = r_exp - adj;
      else if (tiny && UnEn) ef = r_exp + adj;
      else if (!r_hidden)    ef = '0;
      Flags[FLAG_OF] = r_ovf;
      Flags[FLAG_UF] = UnEn ? tiny : (tiny & r_inexact);
      Flags[FLAG_NX] = r_inexact;
      result = fp_pack(res_sign, ef[10:0], r_frac, P);
    end
  end

  assign Denorm = P ? ((result[30:23] == '0) && (result[22:0] != '0))
                    : ((result[62:52] == '0) && (result[51:0] != '0));

  always_ff @(posedge clk) begin
    if (!reset) sticky_flags <= '0;
    else        sticky_flags <= sticky_flags | Flags;
  end

endmodule

// File: tb/tb_fp_add.sv
// tb_fp_add: directed-vector bench for fp_add with hand-computed results.
module tb_fp_add;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] op1, op2;
  logic [2:0]  rm, op_type;
  logic        P, OvEn, UnEn;
  logic [63:0] result;
  logic [4:0]  Flags;
  logic        Denorm;
  logic [4:0]  sticky_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_add dut (
    .clk          (clk),
    .reset        (reset),
    .op1          (op1),
    .op2          (op2),
    .rm           (rm),
    .op_type      (op_type),
    .P            (P),
    .OvEn         (OvEn),
    .UnEn         (UnEn),
    .result       (result),
    .Flags        (Flags),
    .Denorm       (Denorm),
    .sticky_flags (sticky_flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [2:0] m,
                       input logic [2:0] t, input logic p, input logic ov, input logic un);
    @(negedge clk);
    op1 = a; op2 = b; rm = m; op_type = t; P = p; OvEn = ov; UnEn = un;
    #1;
  endtask

  task automatic vec(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic [2:0] m, input logic [2:0] t, input logic p,
                     input logic ov, input logic un,
                     input logic [63:0] exp_r, input logic [4:0] exp_f, input logic exp_d);
    drive(a, b, m, t, p, ov, un);
    check({tag, ".result"}, result, exp_r);
    check({tag, ".flags"}, {59'b0, Flags}, {59'b0, exp_f});
    check({tag, ".denorm"}, {63'b0, Denorm}, {63'b0, exp_d});
  endtask

  initial begin
    reset = 1'b0;
    op1 = '0; op2 = '0; rm = 3'b000; op_type = 3'b000; P = 1'b0; OvEn = 1'b0; UnEn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_sticky", {59'b0, sticky_flags}, 64'h0);

    // reset held low: combinational path exercised without accumulation
    vec("add_exact",  64'h3FF0000000000000, 64'h3FF0000000000000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h4000000000000000, 5'b00000, 1'b0);
    vec("nx_rz",      64'h3FF0000000000000, 64'h3CA0000000000000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h3FF0000000000000, 5'b00001, 1'b0);
    vec("nx_rup",     64'h3FF0000000000000, 64'h3CA0000000000000, 3'b011, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h3FF0000000000001, 5'b00001, 1'b0);
    vec("tie_rne",    64'h3FF0000000000000, 64'h3CA0000000000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h3FF0000000000000, 5'b00001, 1'b0);
    vec("tie_rmm",    64'h3FF0000000000000, 64'h3CA0000000000000, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h3FF0000000000001, 5'b00001, 1'b0);
    vec("ovf_rz",     64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h7FEFFFFFFFFFFFFF, 5'b00101, 1'b0);
    vec("ovf_rne",    64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h7FF0000000000000, 5'b00101, 1'b0);
    vec("ovf_rdn_p",  64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h7FEFFFFFFFFFFFFF, 5'b00101, 1'b0);
    vec("ovf_rup_n",  64'hFFEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 3'b011, 3'b000, 1'b0, 1'b0, 1'b0,
        64'hFFEFFFFFFFFFFFFF, 5'b00101, 1'b0);
    vec("ovf_rdn_n",  64'hFFEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0,
        64'hFFF0000000000000, 5'b00101, 1'b0);
    vec("ovf_trap",   64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0,
        64'h1FFFFFFFFFFFFFFF, 5'b00100, 1'b0);
    vec("inf_m_inf",  64'h7FF0000000000000, 64'hFFF0000000000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h7FF8000000000000, 5'b10000, 1'b0);
    vec("inf_p_fin",  64'h7FF0000000000000, 64'h3FF0000000000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h7FF0000000000000, 5'b00000, 1'b0);
    vec("snan",       64'h7FF0000000000001, 64'h3FF0000000000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h7FF8000000000000, 5'b10000, 1'b0);
    vec("qnan",       64'h3FF0000000000000, 64'h7FF8000000000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h7FF8000000000000, 5'b00000, 1'b0);
    vec("cancel_rz",  64'h3FF0000000000000, 64'hBFF0000000000000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h0000000000000000, 5'b00000, 1'b0);
    vec("cancel_rdn", 64'h3FF0000000000000, 64'hBFF0000000000000, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h8000000000000000, 5'b00000, 1'b0);
    vec("neg_zeros",  64'h8000000000000000, 64'h8000000000000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h8000000000000000, 5'b00000, 1'b0);
    vec("sub_op",     64'h4000000000000000, 64'h3FF0000000000000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0,
        64'h3FF0000000000000, 5'b00000, 1'b0);
    vec("sub_cancel", 64'h3FF0000000000000, 64'h3FF0000000000000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0,
        64'h0000000000000000, 5'b00000, 1'b0);
    vec("subnorm",    64'h0000000000000001, 64'h0000000000000001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
        64'h0000000000000002, 5'b00000, 1'b1);
    vec("unf_trap",   64'h0000000000000001, 64'h0000000000000001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1,
        64'h5CE0000000000000, 5'b00010, 1'b0);
    vec("s_add",      64'h000000003F800000, 64'h000000003F800000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0,
        64'h0000000040000000, 5'b00000, 1'b0);
    vec("s_nx_rup",   64'h000000003F800000, 64'h0000000033800000, 3'b011, 3'b000, 1'b1, 1'b0, 1'b0,
        64'h000000003F800001, 5'b00001, 1'b0);
    vec("s_ovf_rz",   64'h000000007F7FFFFF, 64'h000000007F7FFFFF, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0,
        64'h000000007F7FFFFF, 5'b00101, 1'b0);
    vec("s_inv",      64'h000000007F800000, 64'h00000000FF800000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0,
        64'h000000007FC00000, 5'b10000, 1'b0);

    check("sticky_held", {59'b0, sticky_flags}, 64'h0);

    // Sticky accumulation and reset priority
    drive(64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("sticky_ovf", {59'b0, sticky_flags}, 64'h05);

    drive(64'h7FF0000000000000, 64'hFFF0000000000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("sticky_accum", {59'b0, sticky_flags}, 64'h15);

    drive(64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("flags_live", {59'b0, Flags}, 64'h05);
    @(posedge clk);
    #1;
    check("sticky_clear", {59'b0, sticky_flags}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
